wb_stream_master: RTL and testbench
===================================

WB_STREAM_MASTER -- requirements
Module: wb_stream_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255; max wait cycles for wb_ack_i per access before abort.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-007 SHALL have port cmd_addr  input  [0:23]  start byte address.
REQ-008 SHALL have port cmd_len  input  [0:15]  byte count minus one.
REQ-009 SHALL have port wr_data  input  [0:7]  write stream byte.
REQ-010 SHALL have ports wr_valid input 1 and wr_ready output 1; a byte transfers when both are high.
REQ-011 SHALL have port rd_data  output  [0:7]  read stream byte.
REQ-012 SHALL have ports rd_valid output 1 and rd_ready input 1; a byte transfers when both are high.
REQ-013 SHALL have port busy  output  1  command in progress.
REQ-014 SHALL have ports done output 1 and error output 1; done is a one-cycle pulse at command end, and error is qualified by done.
REQ-015 SHALL have Wishbone master ports wb_adr_o [0:23], wb_dat_o [0:7], wb_dat_i [0:7], wb_we_o 1, wb_sel_o [0:0], wb_stb_o 1, wb_cyc_o 1 and wb_ack_i 1.

Function
REQ-016 SHALL implement states IDLE, FETCH, STROBE, DELIVER and FINISH.
REQ-017 IDLE SHALL hold cmd_ready=1 and busy=0. On accept it SHALL latch addr, len, dir and count=0, and SHALL go to FETCH for a write or STROBE for a read.
REQ-018 FETCH SHALL hold wr_ready=1. On transfer it SHALL latch wr_data into wb_dat_o and go to STROBE next cycle.
REQ-019 STROBE SHALL hold wb_stb_o=1, wb_we_o=dir and wb_sel_o=1, with wb_adr_o = latched addr.
REQ-020 The block SHALL sample wb_ack_i in every STROBE cycle, including the first, because the slave ack may be combinational. wb_stb_o SHALL deassert the cycle after ack is sampled.
REQ-021 On a read ack, the block SHALL capture wb_dat_i into rd_data on that edge and go to DELIVER.
REQ-022 DELIVER SHALL hold rd_valid=1 with rd_data stable until rd_ready. On transfer it SHALL advance.
REQ-023 On a write ack the block SHALL advance directly.
REQ-024 Advance SHALL be: if count==len go to FINISH; else count+1, addr+1 (mod 2^24, 24'hFFFFFF wraps to 0), then go to FETCH for a write or STROBE for a read.
REQ-025 wb_cyc_o SHALL be 1 in all states except IDLE. It SHALL stay high across stalls on wr_valid or rd_ready.
REQ-026 The timeout counter SHALL clear on STROBE entry and count each STROBE cycle without ack. When it reaches TIMEOUT_CYCLES, the block SHALL drop stb, set the error flag and go to FINISH.
REQ-027 FINISH SHALL last exactly one cycle. In it, done=1, error=flag, busy=0 and cyc=0; the block SHALL then return to IDLE with the flag cleared.
REQ-028 busy SHALL be 1 in FETCH, STROBE and DELIVER.
REQ-029 cmd_ready, wr_ready and rd_valid SHALL be 0 outside their own states. Commands offered while busy SHALL be ignored, not queued.
REQ-030 cmd_len=16'hFFFF SHALL transfer 65536 bytes; the count register SHALL be 16 bits with compare-before-increment so it never overflows.
REQ-031 Only one Wishbone access SHALL be outstanding at a time. wb_adr_o, wb_dat_o and wb_we_o SHALL be stable while wb_stb_o=1.

Reset
REQ-032 With reset_n=0 at a clock edge, the block SHALL go to IDLE. Outputs SHALL then be cmd_ready=1, wr_ready=0, rd_valid=0, busy=0, done=0, error=0, wb_stb_o=0, wb_cyc_o=0, wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0 and rd_data=0.
REQ-033 Reset mid-burst SHALL abort immediately with stb/cyc=0 next cycle and no done pulse. Remaining bytes SHALL be discarded.

Verification
REQ-034 The bench SHALL cover a 3-byte write burst: write, addr 24'h010000, len 2, bytes 11/22/33, combinational ack. Required: writes land at 010000/010001/010002, one done pulse with error=0, and cyc low after.
REQ-035 The bench SHALL cover a 2-byte read with delays: read, addr 24'h800000, len 1, ack delayed 3 cycles, rd_ready held low 5 cycles. Required: rd_data AA then BB, each stable while rd_valid, and stb asserted exactly 4 cycles per access.
REQ-036 The bench SHALL cover address wrap: write at 24'hFFFFFF, len 1. Required: second access at 24'h000000.
REQ-037 The bench SHALL cover timeout: with TIMEOUT_CYCLES=4 and no ack, read len 0. Required: stb drops after 4 cycles, done=1 with error=1, then IDLE.
REQ-038 The bench SHALL cover a stream stall: wr_valid low 10 cycles between bytes. Required: cyc stays 1, stb stays 0 during the stall, and no spurious write.
REQ-039 The bench SHALL cover reset mid-burst: assert reset_n=0 during STROBE of byte 2 of 4. Required: next cycle stb=0, cyc=0 and cmd_ready=1, with no done pulse.

Source files
------------

// File: rtl/wb_stream_master_if.sv
// Bundles the command, byte-stream, status and Wishbone master signals of
// wb_stream_master. The master modport is the block's view; the slave
// modport is the surrounding system's view.
interface wb_stream_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [0:23] cmd_addr;
  logic [0:15] cmd_len;

  logic [0:7]  wr_data;
  logic        wr_valid;
  logic        wr_ready;

  logic [0:7]  rd_data;
  logic        rd_valid;
  logic        rd_ready;

  logic        busy;
  logic        done;
  logic        error;

  logic [0:23] wb_adr_o;
  logic [0:7]  wb_dat_o;
  logic [0:7]  wb_dat_i;
  logic        wb_we_o;
  logic [0:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_data, wr_valid, rd_ready,
    input  wb_dat_i, wb_ack_i,
    output cmd_ready, wr_ready, rd_data, rd_valid,
    output busy, done, error,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_data, wr_valid, rd_ready,
    output wb_dat_i, wb_ack_i,
    input  cmd_ready, wr_ready, rd_data, rd_valid,
    input  busy, done, error,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/wb_stream_master.sv
// Byte-stream to Wishbone burst master. A command names a start address and
// length; write bursts pull bytes from the wr stream and issue one Wishbone
// write per byte, read bursts issue one Wishbone read per byte and push the
// result on the rd stream. One access is outstanding at a time, and each
// access is aborted with an error if the slave does not ack in time.
module wb_stream_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 reset_n,
  wb_stream_master_if.master  bus
);

  // Timeout counter holds 0 .. TIMEOUT_CYCLES-1; the last value aborts.
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STROBE,
    S_DELIVER,
    S_FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [0:23]   addr_q,  addr_d;
  logic [0:15]   len_q,   len_d;
  logic [0:15]   cnt_q,   cnt_d;
  logic          dir_q,   dir_d;
  logic [0:7]    dat_q,   dat_d;
  logic [0:7]    rdat_q,  rdat_d;
  logic [TW-1:0] to_q,    to_d;
  logic          err_q,   err_d;
  logic          advance;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      dat_q   <= '0;
      rdat_q  <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath updates; ack is checked before the timeout so a
  // combinational ack in the last permitted cycle still completes the access.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    to_d    = to_q;
    err_d   = err_q;
    advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          len_d   = bus.cmd_len;
          dir_d   = bus.cmd_write;
          cnt_d   = '0;
          err_d   = 1'b0;
          to_d    = '0;
          state_d = bus.cmd_write ? S_FETCH : S_STROBE;
        end
      end

      S_FETCH: begin
        if (bus.wr_valid) begin
          dat_d   = bus.wr_data;
          to_d    = '0;
          state_d = S_STROBE;
        end
      end

      S_STROBE: begin
        if (bus.wb_ack_i) begin
          if (dir_q) begin
            advance = 1'b1;
          end else begin
            rdat_d  = bus.wb_dat_i;
            state_d = S_DELIVER;
          end
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      S_DELIVER: begin
        if (bus.rd_ready) begin
          advance = 1'b1;
        end
      end

      S_FINISH: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Compare before increment so a full 16-bit length never wraps the count.
    if (advance) begin
      if (cnt_q == len_q) begin
        state_d = S_FINISH;
      end else begin
        cnt_d   = cnt_q + 16'd1;
        addr_d  = addr_q + 24'd1;
        to_d    = '0;
        state_d = dir_q ? S_FETCH : S_STROBE;
      end
    end
  end

  // Outputs decode directly from the registered state.
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.wr_ready  = (state_q == S_FETCH);
  assign bus.rd_valid  = (state_q == S_DELIVER);
  assign bus.rd_data   = rdat_q;
  assign bus.busy      = (state_q == S_FETCH) || (state_q == S_STROBE) ||
                         (state_q == S_DELIVER);
  assign bus.done      = (state_q == S_FINISH);
  assign bus.error     = (state_q == S_FINISH) && err_q;
  assign bus.wb_stb_o  = (state_q == S_STROBE);
  assign bus.wb_cyc_o  = bus.busy;
  assign bus.wb_we_o   = (state_q == S_STROBE) && dir_q;
  assign bus.wb_sel_o  = {(state_q == S_STROBE)};
  assign bus.wb_adr_o  = addr_q;
  assign bus.wb_dat_o  = dat_q;

endmodule

// File: tb/tb_wb_stream_master.sv
// Directed bench for wb_stream_master with a scoreboard monitor.
module tb_wb_stream_master;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  wb_stream_master_if bus();

  wb_stream_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [0:23] adr;
    logic [0:7]  dat;
  } wr_t;

  wr_t         exp_wr[$];
  logic [0:7]  exp_rd[$];
  logic        exp_done[$];
  int unsigned exp_stb_len;

  int checks = 0;
  int errors = 0;

  // Wishbone slave: combinational ack after ack_delay stalled strobe cycles.
  int unsigned ack_delay;
  logic        ack_en;
  int unsigned stb_cnt;

  always @(posedge clk) begin
    if (!reset_n || !bus.wb_stb_o) stb_cnt <= 0;
    else                           stb_cnt <= stb_cnt + 1;
  end

  assign bus.wb_ack_i = bus.wb_stb_o && ack_en && (stb_cnt == ack_delay);
  assign bus.wb_dat_i = (bus.wb_adr_o == 24'h800000) ? 8'hAA :
                        (bus.wb_adr_o == 24'h800001) ? 8'hBB : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: samples mid-cycle, pops expectations on each event.
  int unsigned run = 0;
  int unsigned last_run = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run = 0;
      end else begin
        if (bus.wb_stb_o) begin
          run++;
          if (bus.wb_ack_i) begin
            chk("stb_len", run, exp_stb_len);
            run = 0;
            if (bus.wb_we_o) begin
              if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_write actual=%h/%h required=none",
                         bus.wb_adr_o, bus.wb_dat_o);
              end else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("wb_adr", {8'h00, bus.wb_adr_o}, {8'h00, w.adr});
                chk("wb_dat", {24'h0, bus.wb_dat_o}, {24'h0, w.dat});
              end
            end
          end
        end else if (run != 0) begin
          last_run = run;
          run = 0;
        end

        if (bus.rd_valid) begin
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_rd_valid actual=%h required=none", bus.rd_data);
          end else begin
            chk("rd_data", {24'h0, bus.rd_data}, {24'h0, exp_rd[0]});
            if (bus.rd_ready) void'(exp_rd.pop_front());
          end
        end

        if (bus.done) begin
          if (exp_done.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_done actual=1 required=0");
          end else begin
            logic e;
            e = exp_done.pop_front();
            chk("done_error", {31'h0, bus.error}, {31'h0, e});
            chk("finish_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
            chk("finish_busy", {31'h0, bus.busy}, 32'h0);
            if (e) chk("timeout_stb_len", last_run, exp_stb_len);
          end
        end
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [0:23] adr, input logic [0:15] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = we;
    bus.cmd_addr  = adr;
    bus.cmd_len   = len;
    for (int i = 0; i < 50 && !bus.cmd_ready; i++) wait_cycle();
    chk("cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    wait_cycle();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [0:7] b);
    bus.wr_valid = 1'b1;
    bus.wr_data  = b;
    for (int i = 0; i < 50 && !bus.wr_ready; i++) wait_cycle();
    chk("wr_ready", {31'h0, bus.wr_ready}, 32'h1);
    wait_cycle();
    bus.wr_valid = 1'b0;
  endtask

  task automatic recv_byte(input int unsigned hold);
    for (int i = 0; i < 50 && !bus.rd_valid; i++) wait_cycle();
    chk("rd_valid", {31'h0, bus.rd_valid}, 32'h1);
    repeat (hold) wait_cycle();
    bus.rd_ready = 1'b1;
    wait_cycle();
    bus.rd_ready = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && !bus.done; i++) wait_cycle();
    chk("done_seen", {31'h0, bus.done}, 32'h1);
    wait_cycle();
    chk("after_done_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    chk("after_done_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    chk("after_done_pulse", {31'h0, bus.done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    ack_en        = 1'b1;
    ack_delay     = 0;
    exp_stb_len   = 1;
    repeat (3) wait_cycle();

    // Reset state
    chk("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    chk("rst_wr_ready",  {31'h0, bus.wr_ready},  32'h0);
    chk("rst_rd_valid",  {31'h0, bus.rd_valid},  32'h0);
    chk("rst_busy",      {31'h0, bus.busy},      32'h0);
    chk("rst_done",      {31'h0, bus.done},      32'h0);
    chk("rst_error",     {31'h0, bus.error},     32'h0);
    chk("rst_stb",       {31'h0, bus.wb_stb_o},  32'h0);
    chk("rst_cyc",       {31'h0, bus.wb_cyc_o},  32'h0);
    chk("rst_we",        {31'h0, bus.wb_we_o},   32'h0);
    chk("rst_sel",       {31'h0, bus.wb_sel_o},  32'h0);
    chk("rst_adr",       {8'h0, bus.wb_adr_o},   32'h0);
    chk("rst_dat",       {24'h0, bus.wb_dat_o},  32'h0);
    chk("rst_rd_data",   {24'h0, bus.rd_data},   32'h0);
    reset_n = 1'b1;
    wait_cycle();

    // 3-byte write burst, combinational ack
    ack_delay = 0; exp_stb_len = 1;
    exp_wr.push_back('{24'h010000, 8'h11});
    exp_wr.push_back('{24'h010001, 8'h22});
    exp_wr.push_back('{24'h010002, 8'h33});
    exp_done.push_back(1'b0);
    send_cmd(1'b1, 24'h010000, 16'd2);
    chk("write_busy", {31'h0, bus.busy}, 32'h1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    wait_done();

    // 2-byte read, ack after 3 cycles, rd_ready held off 5 cycles
    ack_delay = 3; exp_stb_len = 4;
    exp_rd.push_back(8'hAA);
    exp_rd.push_back(8'hBB);
    exp_done.push_back(1'b0);
    send_cmd(1'b0, 24'h800000, 16'd1);
    recv_byte(5);
    chk("deliver_cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
    recv_byte(5);
    wait_done();

    // Address wrap
    ack_delay = 0; exp_stb_len = 1;
    exp_wr.push_back('{24'hFFFFFF, 8'h66});
    exp_wr.push_back('{24'h000000, 8'h77});
    exp_done.push_back(1'b0);
    send_cmd(1'b1, 24'hFFFFFF, 16'd1);
    send_byte(8'h66);
    send_byte(8'h77);
    wait_done();

    // Stream stall between bytes; a command offered meanwhile is ignored
    exp_wr.push_back('{24'h000100, 8'h44});
    exp_wr.push_back('{24'h000101, 8'h55});
    exp_done.push_back(1'b0);
    send_cmd(1'b1, 24'h000100, 16'd1);
    send_byte(8'h44);
    wait_cycle();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 24'h123456;
    bus.cmd_len   = 16'd7;
    for (int i = 0; i < 10; i++) begin
      chk("stall_cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
      chk("stall_stb", {31'h0, bus.wb_stb_o}, 32'h0);
      chk("stall_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
      wait_cycle();
    end
    bus.cmd_valid = 1'b0;
    send_byte(8'h55);
    wait_done();

    // Timeout with no ack
    ack_en = 1'b0; exp_stb_len = 4;
    exp_done.push_back(1'b1);
    send_cmd(1'b0, 24'h000300, 16'd0);
    wait_done();
    ack_en = 1'b1;

    // Reset during the strobe of byte 2 of 4
    ack_delay = 2; exp_stb_len = 3;
    exp_wr.push_back('{24'h000200, 8'h01});
    send_cmd(1'b1, 24'h000200, 16'd3);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("mid_stb", {31'h0, bus.wb_stb_o}, 32'h1);
    chk("mid_adr", {8'h0, bus.wb_adr_o}, 32'h000201);
    reset_n = 1'b0;
    wait_cycle();
    chk("abort_stb", {31'h0, bus.wb_stb_o}, 32'h0);
    chk("abort_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    chk("abort_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    chk("abort_adr", {8'h0, bus.wb_adr_o}, 32'h0);
    chk("abort_rd_data", {24'h0, bus.rd_data}, 32'h0);
    reset_n = 1'b1;
    repeat (8) begin
      wait_cycle();
      chk("abort_idle_busy", {31'h0, bus.busy}, 32'h0);
    end

    chk("left_wr", exp_wr.size(), 32'h0);
    chk("left_rd", exp_rd.size(), 32'h0);
    chk("left_done", exp_done.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
